// File: rtl/pipe_defs.sv
// pipe_defs: shared definitions for the pipeline valid/allow-in sequencer.
//   - pipe_state_e : sequencer FSM encoding (BOOT, RUN)
//   - IF..WB       : stage index constants
//   - PERF_W_DEFAULT : default performance counter width
package pipe_defs;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } pipe_state_e;

   localparam int unsigned IF  = 0;
   localparam int unsigned ID  = 1;
   localparam int unsigned EXE = 2;
   localparam int unsigned MEM = 3;
   localparam int unsigned WB  = 4;

   localparam int unsigned NUM_STAGES = 5;

   localparam int unsigned PERF_W_DEFAULT = 32;

endpackage

// File: rtl/pipe_stage_valid.sv
// pipe_stage_valid: one stage-valid flag of the pipeline.
// Ports:
//   clk, resetn  clock and synchronous active-low reset
//   allow_in     this stage can accept a new instruction this edge
//   prev_fire    upstream stage holds a finished instruction
//   flush        drop the held instruction (tied low for WB)
//   valid        stage holds a live instruction
module pipe_stage_valid (
   input  logic clk,
   input  logic resetn,
   input  logic allow_in,
   input  logic prev_fire,
   input  logic flush,
   output logic valid
);

   logic valid_q;
   logic valid_d;

   // Flush wins over any advance; otherwise load on allow_in, else hold.
   always_comb begin
      valid_d = valid_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (allow_in) begin
         valid_d = prev_fire;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

   assign valid = valid_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: valid/allow-in sequencer for the five-stage pipeline.
// Owns all stage-valid flags, inter-stage latch enables, the fetch strobe
// and the exception flush. Stages only report their *_over flags.
// Ports:
//   clk, resetn                         clock, synchronous active-low reset
//   IF_over..WB_over                    stage finished its instruction
//   exc_valid                           exception/eret taken in WB
//   IF_valid..WB_valid                  stage holds a live instruction
//   next_fetch                          fetch loads next PC (or exception PC)
//   IF_ID_en, ID_EXE_en, EXE_MEM_en,
//   MEM_WB_en                           latch downstream inter-stage bus
//   cancel                              registered one-cycle flush
//   perf_cycles, perf_retired,
//   perf_stalls                         counters, only with PIPE_PERF_EN
// Build option: define PIPE_PERF_EN to add the performance counters and
// the PERF_W parameter.
module pipe_ctrl
   import pipe_defs::*;
`ifdef PIPE_PERF_EN
#(
   parameter int unsigned PERF_W = PERF_W_DEFAULT
)
`endif
(
   input  logic clk,
   input  logic resetn,
   input  logic IF_over,
   input  logic ID_over,
   input  logic EXE_over,
   input  logic MEM_over,
   input  logic WB_over,
   input  logic exc_valid,
   output logic IF_valid,
   output logic ID_valid,
   output logic EXE_valid,
   output logic MEM_valid,
   output logic WB_valid,
   output logic next_fetch,
   output logic IF_ID_en,
   output logic ID_EXE_en,
   output logic EXE_MEM_en,
   output logic MEM_WB_en,
   output logic cancel
`ifdef PIPE_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_cycles,
   output logic [PERF_W-1:0] perf_retired,
   output logic [PERF_W-1:0] perf_stalls
`endif
);

   pipe_state_e state_q;
   pipe_state_e state_d;
   logic        if_valid_q;
   logic        cancel_q;

   logic id_allow_in;
   logic exe_allow_in;
   logic mem_allow_in;
   logic wb_allow_in;

   logic if_fire;
   logic id_fire;
   logic exe_fire;
   logic mem_fire;

   // Sequencer FSM
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         BOOT:    state_d = RUN;
         RUN:     state_d = RUN;
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= BOOT;
         if_valid_q <= 1'b0;
         cancel_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         // IF goes live one edge after entering RUN.
         if_valid_q <= (state_q == RUN);
         // The !cancel_q term limits a held exc_valid to one flush per
         // two cycles, so each flush is a single cycle.
         cancel_q   <= exc_valid & WB_valid & WB_over & ~cancel_q;
      end
   end

   // Allow-in chain, computed from WB backwards
   assign wb_allow_in  = ~WB_valid  | WB_over;
   assign mem_allow_in = ~MEM_valid | (MEM_over & wb_allow_in);
   assign exe_allow_in = ~EXE_valid | (EXE_over & mem_allow_in);
   assign id_allow_in  = ~ID_valid  | (ID_over  & exe_allow_in);

   assign if_fire  = IF_valid  & IF_over;
   assign id_fire  = ID_valid  & ID_over;
   assign exe_fire = EXE_valid & EXE_over;
   assign mem_fire = MEM_valid & MEM_over;

   assign IF_ID_en   = if_fire  & id_allow_in;
   assign ID_EXE_en  = id_fire  & exe_allow_in;
   assign EXE_MEM_en = exe_fire & mem_allow_in;
   assign MEM_WB_en  = mem_fire & wb_allow_in;

   // On cancel the fetch stage loads the exception PC instead.
   assign next_fetch = IF_ID_en | cancel_q;

   assign IF_valid = if_valid_q;
   assign cancel   = cancel_q;

   pipe_stage_valid u_id_valid (
      .clk       (clk),
      .resetn    (resetn),
      .allow_in  (id_allow_in),
      .prev_fire (if_fire),
      .flush     (cancel_q),
      .valid     (ID_valid)
   );

   pipe_stage_valid u_exe_valid (
      .clk       (clk),
      .resetn    (resetn),
      .allow_in  (exe_allow_in),
      .prev_fire (id_fire),
      .flush     (cancel_q),
      .valid     (EXE_valid)
   );

   pipe_stage_valid u_mem_valid (
      .clk       (clk),
      .resetn    (resetn),
      .allow_in  (mem_allow_in),
      .prev_fire (exe_fire),
      .flush     (cancel_q),
      .valid     (MEM_valid)
   );

   // The faulting instruction itself must still retire in WB.
   pipe_stage_valid u_wb_valid (
      .clk       (clk),
      .resetn    (resetn),
      .allow_in  (wb_allow_in),
      .prev_fire (mem_fire),
      .flush     (1'b0),
      .valid     (WB_valid)
   );

`ifdef PIPE_PERF_EN
   logic [PERF_W-1:0] cycles_q;
   logic [PERF_W-1:0] retired_q;
   logic [PERF_W-1:0] stalls_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cycles_q  <= '0;
         retired_q <= '0;
         stalls_q  <= '0;
      end else begin
         if (state_q == RUN) begin
            cycles_q <= cycles_q + PERF_W'(1);
         end
         if (WB_valid & WB_over) begin
            retired_q <= retired_q + PERF_W'(1);
         end
         if (IF_valid & ~next_fetch) begin
            stalls_q <= stalls_q + PERF_W'(1);
         end
      end
   end

   assign perf_cycles  = cycles_q;
   assign perf_retired = retired_q;
   assign perf_stalls  = stalls_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl.
// Define PIPE_PERF_EN to also build and check the performance counters.
module tb_pipe_ctrl;

   logic clk;
   logic resetn;
   logic IF_over, ID_over, EXE_over, MEM_over, WB_over;
   logic exc_valid;
   logic IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid;
   logic next_fetch;
   logic IF_ID_en, ID_EXE_en, EXE_MEM_en, MEM_WB_en;
   logic cancel;

   int total;
   int bad;

   // {WB, MEM, EXE, ID, IF}
   logic [4:0]  vld;
   logic [10:0] all_outs;
   assign vld = {WB_valid, MEM_valid, EXE_valid, ID_valid, IF_valid};
   assign all_outs = {IF_valid, ID_valid, EXE_valid, MEM_valid, WB_valid, next_fetch,
                      IF_ID_en, ID_EXE_en, EXE_MEM_en, MEM_WB_en, cancel};

`ifdef PIPE_PERF_EN
   logic [3:0] perf_cycles, perf_retired, perf_stalls;

   pipe_ctrl #(
      .PERF_W (4)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .IF_over      (IF_over),
      .ID_over      (ID_over),
      .EXE_over     (EXE_over),
      .MEM_over     (MEM_over),
      .WB_over      (WB_over),
      .exc_valid    (exc_valid),
      .IF_valid     (IF_valid),
      .ID_valid     (ID_valid),
      .EXE_valid    (EXE_valid),
      .MEM_valid    (MEM_valid),
      .WB_valid     (WB_valid),
      .next_fetch   (next_fetch),
      .IF_ID_en     (IF_ID_en),
      .ID_EXE_en    (ID_EXE_en),
      .EXE_MEM_en   (EXE_MEM_en),
      .MEM_WB_en    (MEM_WB_en),
      .cancel       (cancel),
      .perf_cycles  (perf_cycles),
      .perf_retired (perf_retired),
      .perf_stalls  (perf_stalls)
   );
`else
   pipe_ctrl dut (
      .clk        (clk),
      .resetn     (resetn),
      .IF_over    (IF_over),
      .ID_over    (ID_over),
      .EXE_over   (EXE_over),
      .MEM_over   (MEM_over),
      .WB_over    (WB_over),
      .exc_valid  (exc_valid),
      .IF_valid   (IF_valid),
      .ID_valid   (ID_valid),
      .EXE_valid  (EXE_valid),
      .MEM_valid  (MEM_valid),
      .WB_valid   (WB_valid),
      .next_fetch (next_fetch),
      .IF_ID_en   (IF_ID_en),
      .ID_EXE_en  (ID_EXE_en),
      .EXE_MEM_en (EXE_MEM_en),
      .MEM_WB_en  (MEM_WB_en),
      .cancel     (cancel)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_over(input logic v);
      IF_over  = v;
      ID_over  = v;
      EXE_over = v;
      MEM_over = v;
      WB_over  = v;
   endtask

   task automatic test_reset();
      resetn    = 1'b0;
      exc_valid = 1'b0;
      set_over(1'b1);
      tick();
      tick();
      total++;
      if (all_outs !== 11'b0) begin
         bad++;
         $display("FAIL reset_outputs: got %b want %b", all_outs, 11'b0);
      end
   endtask

   // Reset release with all stages finishing every cycle.
   task automatic test_fill();
      logic [4:0] exp_vld [6];
      logic       exp_nf  [6];
      exp_vld = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111};
      exp_nf  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      resetn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         total++;
         if (vld !== exp_vld[i]) begin
            bad++;
            $display("FAIL fill_valid edge %0d: got %b want %b", i + 1, vld, exp_vld[i]);
         end
         total++;
         if (next_fetch !== exp_nf[i]) begin
            bad++;
            $display("FAIL fill_next_fetch edge %0d: got %b want %b", i + 1, next_fetch,
                     exp_nf[i]);
         end
      end
   endtask

   // EXE stalls for three edges on a full pipeline.
   task automatic test_stall();
      logic [4:0] exp_vld [3];
      exp_vld = '{5'b10111, 5'b00111, 5'b00111};
      EXE_over = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if ({IF_ID_en, ID_EXE_en, EXE_MEM_en, next_fetch} !== 4'b0000) begin
            bad++;
            $display("FAIL stall_enables cycle %0d: got %b want %b", i,
                     {IF_ID_en, ID_EXE_en, EXE_MEM_en, next_fetch}, 4'b0000);
         end
         tick();
         total++;
         if (vld !== exp_vld[i]) begin
            bad++;
            $display("FAIL stall_valid cycle %0d: got %b want %b", i, vld, exp_vld[i]);
         end
      end
      EXE_over = 1'b1;
      #1;
      total++;
      if ({IF_ID_en, ID_EXE_en, EXE_MEM_en} !== 3'b111) begin
         bad++;
         $display("FAIL stall_release_en: got %b want %b", {IF_ID_en, ID_EXE_en, EXE_MEM_en},
                  3'b111);
      end
      tick();
      total++;
      if (vld !== 5'b01111) begin
         bad++;
         $display("FAIL stall_release_mem: got %b want %b", vld, 5'b01111);
      end
      tick();
      total++;
      if (vld !== 5'b11111) begin
         bad++;
         $display("FAIL stall_refull: got %b want %b", vld, 5'b11111);
      end
   endtask

   // Single-cycle exception on a full pipeline.
   task automatic test_flush();
      exc_valid = 1'b1;
      #1;
      total++;
      if (cancel !== 1'b0) begin
         bad++;
         $display("FAIL flush_pre_cancel: got %b want 0", cancel);
      end
      tick();
      exc_valid = 1'b0;
      total++;
      if ({cancel, next_fetch, vld} !== {2'b11, 5'b11111}) begin
         bad++;
         $display("FAIL flush_cancel_cycle: got %b want %b", {cancel, next_fetch, vld},
                  {2'b11, 5'b11111});
      end
      tick();
      total++;
      if ({cancel, vld} !== {1'b0, 5'b10001}) begin
         bad++;
         $display("FAIL flush_cleared: got %b want %b", {cancel, vld}, {1'b0, 5'b10001});
      end
      tick();
      total++;
      if ({cancel, vld} !== {1'b0, 5'b00011}) begin
         bad++;
         $display("FAIL flush_restart: got %b want %b", {cancel, vld}, {1'b0, 5'b00011});
      end
   endtask

   // exc_valid held for four edges once the pipeline is full again.
   task automatic test_exc_hold();
      logic       exp_cancel [4];
      logic [4:0] exp_vld    [4];
      exp_cancel = '{1'b1, 1'b0, 1'b1, 1'b0};
      exp_vld    = '{5'b11111, 5'b10001, 5'b00011, 5'b00001};
      tick();
      tick();
      tick();
      total++;
      if (vld !== 5'b11111) begin
         bad++;
         $display("FAIL hold_prefill: got %b want %b", vld, 5'b11111);
      end
      exc_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if ({cancel, vld} !== {exp_cancel[i], exp_vld[i]}) begin
            bad++;
            $display("FAIL hold_cancel edge %0d: got %b want %b", i, {cancel, vld},
                     {exp_cancel[i], exp_vld[i]});
         end
      end
      exc_valid = 1'b0;
   endtask

   // Reset asserted during a stall with cancel pending.
   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) tick();
      total++;
      if (vld !== 5'b11111) begin
         bad++;
         $display("FAIL midrst_prefill: got %b want %b", vld, 5'b11111);
      end
      EXE_over  = 1'b0;
      exc_valid = 1'b1;
      tick();
      total++;
      if ({cancel, vld} !== {1'b1, 5'b10111}) begin
         bad++;
         $display("FAIL midrst_pending: got %b want %b", {cancel, vld}, {1'b1, 5'b10111});
      end
      resetn    = 1'b0;
      exc_valid = 1'b0;
      tick();
      total++;
      if (all_outs !== 11'b0) begin
         bad++;
         $display("FAIL midrst_cleared: got %b want %b", all_outs, 11'b0);
      end
      resetn   = 1'b1;
      EXE_over = 1'b1;
      tick();
      total++;
      if (IF_valid !== 1'b0) begin
         bad++;
         $display("FAIL midrst_boot: IF_valid got %b want 0", IF_valid);
      end
      tick();
      total++;
      if (IF_valid !== 1'b1) begin
         bad++;
         $display("FAIL midrst_run: IF_valid got %b want 1", IF_valid);
      end
   endtask

`ifdef PIPE_PERF_EN
   // 20 RUN edges wrap a 4-bit cycle counter to 4; WB retires on 15 of them.
   task automatic test_perf();
      resetn = 1'b0;
      set_over(1'b1);
      tick();
      total++;
      if ({perf_cycles, perf_retired, perf_stalls} !== 12'h000) begin
         bad++;
         $display("FAIL perf_reset: got %h want %h",
                  {perf_cycles, perf_retired, perf_stalls}, 12'h000);
      end
      resetn = 1'b1;
      for (int i = 0; i < 21; i++) tick();
      total++;
      if ({perf_cycles, perf_retired, perf_stalls} !== 12'h4F0) begin
         bad++;
         $display("FAIL perf_counts: got %h want %h",
                  {perf_cycles, perf_retired, perf_stalls}, 12'h4F0);
      end
   endtask
`endif

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_fill();
      test_stall();
      test_flush();
      test_exc_hold();
      test_reset_mid();
`ifdef PIPE_PERF_EN
      test_perf();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
